// File: rtl/page_walker_pkg.sv
// Shared definitions for the page-table walker: walk states, PTE bit
// positions and per-level index geometry.
package page_walker_pkg;

    localparam int IDX_W     = 9;
    localparam int PTE_SHIFT = 3;
    localparam int PTE_V     = 0;
    localparam int PTE_L     = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_INSERT = 3'd3,
        ST_FAULT  = 3'd4,
        ST_DRAIN  = 3'd5
    } walk_state_e;

endpackage

// File: rtl/page_walker_pte_addr_gen.sv
// Combinational PTE address for one level: base + 8 * (9-bit VA index of that level).
module pte_addr_gen
    import page_walker_pkg::*;
#(
    parameter int SADDR  = 64,
    parameter int SPAGE  = 12,
    parameter int NLEVEL = 3,
    parameter int LW     = 2
) (
    input  logic [SADDR-1:0] va,
    input  logic [LW-1:0]    level,
    input  logic [SADDR-1:0] base,
    output logic [SADDR-1:0] addr
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        // level 0 indexes the most significant 9-bit field above the page offset
        idx  = IDX_W'(va >> (SPAGE + IDX_W * (NLEVEL - 1 - int'(level))));
        addr = base + (SADDR'(idx) << PTE_SHIFT);
    end

endmodule

// File: rtl/page_walker.sv
// Hardware page-table walker: on a TLB miss, reads one PTE per level and
// either inserts the leaf translation into the TLB or raises a fault.
module page_walker
    import page_walker_pkg::*;
#(
    parameter int SADDR  = 64,
    parameter int SPAGE  = 12,
    parameter int SPCID  = 12,
    parameter int NLEVEL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss,
    input  logic [SADDR-1:0] va,
    input  logic [SPCID-1:0] pcid,
    input  logic [SADDR-1:0] root_pa,
    input  logic             shutdown,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [SADDR-1:0] mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [SADDR-1:0] mem_rsp_data,
    output logic             insert,
    output logic [SADDR-1:0] ins_pa,
    output logic [SADDR-1:0] ins_va,
    output logic [SPCID-1:0] ins_pcid,
    output logic             fault,
    output logic             busy
);

    localparam int LW = (NLEVEL > 1) ? $clog2(NLEVEL) : 1;
    localparam logic [LW-1:0] LAST_LEVEL = LW'(NLEVEL - 1);

    walk_state_e      state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [SADDR-1:0] va_q, va_d;
    logic [SPCID-1:0] pcid_q, pcid_d;
    logic [SADDR-1:0] addr_q, addr_d;
    logic [SADDR-1:0] ins_pa_q, ins_pa_d;
    logic [SADDR-1:0] ins_va_q, ins_va_d;
    logic [SPCID-1:0] ins_pcid_q, ins_pcid_d;
    logic             req_valid_q, req_valid_d;
    logic             insert_q, insert_d;
    logic             fault_q, fault_d;
    logic             busy_q, busy_d;

    logic [SADDR-1:0] gen_va, gen_base, gen_addr;
    logic [LW-1:0]    gen_level;
    logic             pte_v, pte_l, last_level;
    logic             rsp_unused;

    assign pte_v      = mem_rsp_data[PTE_V];
    assign pte_l      = mem_rsp_data[PTE_L];
    assign rsp_unused = ^mem_rsp_data[SPAGE-1:PTE_L+1];
    assign last_level = (level_q == LAST_LEVEL);

    pte_addr_gen #(
        .SADDR (SADDR),
        .SPAGE (SPAGE),
        .NLEVEL(NLEVEL),
        .LW    (LW)
    ) u_addr_gen (
        .va   (gen_va),
        .level(gen_level),
        .base (gen_base),
        .addr (gen_addr)
    );

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        va_d       = va_q;
        pcid_d     = pcid_q;
        addr_d     = addr_q;
        ins_pa_d   = ins_pa_q;
        ins_va_d   = ins_va_q;
        ins_pcid_d = ins_pcid_q;
        // default generator inputs describe the next level of an ongoing walk
        gen_va     = va_q;
        gen_level  = level_q + LW'(1);
        gen_base   = {mem_rsp_data[SADDR-1:SPAGE], {SPAGE{1'b0}}};

        case (state_q)
            ST_IDLE: begin
                gen_va    = va;
                gen_level = '0;
                gen_base  = root_pa;
                if (miss && !shutdown) begin
                    va_d    = va;
                    pcid_d  = pcid;
                    level_d = '0;
                    addr_d  = gen_addr;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (shutdown)           state_d = ST_IDLE;
                else if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (shutdown) begin
                    state_d = mem_rsp_valid ? ST_IDLE : ST_DRAIN;
                end else if (mem_rsp_valid) begin
                    if (!pte_v || (pte_l != last_level)) begin
                        state_d = ST_FAULT;
                    end else if (pte_l) begin
                        ins_pa_d   = {mem_rsp_data[SADDR-1:SPAGE], va_q[SPAGE-1:0]};
                        ins_va_d   = va_q;
                        ins_pcid_d = pcid_q;
                        state_d    = ST_INSERT;
                    end else begin
                        level_d = gen_level;
                        addr_d  = gen_addr;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_rsp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_valid_d = (state_d == ST_REQ);
        insert_d    = (state_d == ST_INSERT);
        fault_d     = (state_d == ST_FAULT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            va_q        <= '0;
            pcid_q      <= '0;
            addr_q      <= '0;
            ins_pa_q    <= '0;
            ins_va_q    <= '0;
            ins_pcid_q  <= '0;
            req_valid_q <= 1'b0;
            insert_q    <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            va_q        <= va_d;
            pcid_q      <= pcid_d;
            addr_q      <= addr_d;
            ins_pa_q    <= ins_pa_d;
            ins_va_q    <= ins_va_d;
            ins_pcid_q  <= ins_pcid_d;
            req_valid_q <= req_valid_d;
            insert_q    <= insert_d;
            fault_q     <= fault_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = addr_q;
    // a shutdown arriving while the insert is presented cancels it
    assign insert        = insert_q & ~shutdown;
    assign ins_pa        = ins_pa_q;
    assign ins_va        = ins_va_q;
    assign ins_pcid      = ins_pcid_q;
    assign fault         = fault_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_page_walker.sv
// Directed bench for page_walker: table of complete walks plus hand-written
// sequences for stalls, shutdown, ignored misses and reset mid-walk.
module tb_page_walker;

    logic        clk = 1'b0;
    logic        rst, miss, shutdown, mem_req_ready, mem_rsp_valid;
    logic [63:0] va, root_pa, mem_rsp_data;
    logic [11:0] pcid;
    logic        mem_req_valid, insert, fault, busy;
    logic [63:0] mem_req_addr, ins_pa, ins_va;
    logic [11:0] ins_pcid;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_pa = '0, last_va = '0;
    logic [11:0] last_pcid = '0;

    always #5 clk = ~clk;

    page_walker #(.SADDR(64), .SPAGE(12), .SPCID(12), .NLEVEL(3)) dut (
        .clk(clk), .rst(rst), .miss(miss), .va(va), .pcid(pcid), .root_pa(root_pa),
        .shutdown(shutdown), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .insert(insert), .ins_pa(ins_pa), .ins_va(ins_va), .ins_pcid(ins_pcid),
        .fault(fault), .busy(busy)
    );

    typedef struct {
        logic [63:0]      va;
        logic [11:0]      pcid;
        logic [63:0]      root;
        int               n;
        logic [2:0][63:0] pte;
        logic [2:0][63:0] addr;
        bit               is_ins;
        logic [63:0]      pa;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(logic [63:0] v, logic [11:0] p, logic [63:0] r, int n,
                                logic [63:0] p0, logic [63:0] p1, logic [63:0] p2,
                                logic [63:0] a0, logic [63:0] a1, logic [63:0] a2,
                                bit ins, logic [63:0] pa);
        vec_t t;
        t.va = v; t.pcid = p; t.root = r; t.n = n;
        t.pte[0] = p0; t.pte[1] = p1; t.pte[2] = p2;
        t.addr[0] = a0; t.addr[1] = a1; t.addr[2] = a2;
        t.is_ins = ins; t.pa = pa;
        return t;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(logic [63:0] v, logic [11:0] p, logic [63:0] r);
        miss = 1'b1; va = v; pcid = p; root_pa = r;
        tick();
        miss = 1'b0; va = '0; pcid = '0; root_pa = '0;
    endtask

    task automatic handshake();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(logic [63:0] d);
        mem_rsp_valid = 1'b1; mem_rsp_data = d;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    endtask

    task automatic run_vec(int i);
        vec_t v;
        v = vecs[i];
        start_miss(v.va, v.pcid, v.root);
        chk($sformatf("v%0d_busy", i), busy, 1);
        for (int l = 0; l < v.n; l++) begin
            chk($sformatf("v%0d_req_valid_l%0d", i, l), mem_req_valid, 1);
            chk($sformatf("v%0d_req_addr_l%0d", i, l), mem_req_addr, v.addr[l]);
            handshake();
            chk($sformatf("v%0d_wait_valid_l%0d", i, l), mem_req_valid, 0);
            respond(v.pte[l]);
        end
        chk($sformatf("v%0d_insert", i), insert, v.is_ins);
        chk($sformatf("v%0d_fault", i), fault, !v.is_ins);
        chk($sformatf("v%0d_no_more_req", i), mem_req_valid, 0);
        if (v.is_ins) begin
            last_pa = v.pa; last_va = v.va; last_pcid = v.pcid;
        end
        chk($sformatf("v%0d_ins_pa", i), ins_pa, last_pa);
        chk($sformatf("v%0d_ins_va", i), ins_va, last_va);
        chk($sformatf("v%0d_ins_pcid", i), ins_pcid, last_pcid);
        tick();
        chk($sformatf("v%0d_pulse_end", i), {insert, fault, busy}, 0);
        chk($sformatf("v%0d_ins_pa_hold", i), ins_pa, last_pa);
    endtask

    initial begin
        vecs[0] = mk(64'h4020_3ABC, 12'h005, 64'h1000, 3, 64'h2001, 64'h3001, 64'h8000_5003,
                     64'h1008, 64'h2008, 64'h3018, 1'b1, 64'h8000_5ABC);
        vecs[1] = mk(64'h4020_3ABC, 12'h005, 64'h1000, 2, 64'h2001, 64'h3000, 64'h0,
                     64'h1008, 64'h2008, 64'h0, 1'b0, 64'h0);
        vecs[2] = mk(64'h4020_3ABC, 12'h005, 64'h1000, 1, 64'h0, 64'h0, 64'h0,
                     64'h1008, 64'h0, 64'h0, 1'b0, 64'h0);
        vecs[3] = mk(64'h4020_3ABC, 12'h005, 64'h1000, 1, 64'h2003, 64'h0, 64'h0,
                     64'h1008, 64'h0, 64'h0, 1'b0, 64'h0);
        vecs[4] = mk(64'h4020_3ABC, 12'h005, 64'h1000, 3, 64'h2001, 64'h3001, 64'h8000_5001,
                     64'h1008, 64'h2008, 64'h3018, 1'b0, 64'h0);
        vecs[5] = mk(64'h8000_007F_C01F_FFFF, 12'hFFF, 64'h7000, 3,
                     64'hA000_0001, 64'hB123_4FF1, 64'hFFFF_FFFF_FFFF_F003,
                     64'h7FF8, 64'hA000_0000, 64'hB123_4FF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

        rst = 1'b1; miss = 1'b0; shutdown = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; va = '0; pcid = '0; root_pa = '0; mem_rsp_data = '0;
        tick(); tick();
        chk("reset_ctrl", {busy, mem_req_valid, insert, fault}, 0);
        chk("reset_addr", mem_req_addr, 0);
        chk("reset_ins", ins_pa | ins_va | 64'(ins_pcid), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i);

        // ready held low: request must stay valid and stable
        start_miss(64'h4020_3ABC, 12'h005, 64'h1000);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("stall_valid_c%0d", c), mem_req_valid, 1);
            chk($sformatf("stall_addr_c%0d", c), mem_req_addr, 64'h1008);
        end
        handshake();
        respond(64'h2001);
        chk("stall_next_addr", mem_req_addr, 64'h2008);
        shutdown = 1'b1; tick(); shutdown = 1'b0;
        chk("shut_req_idle", {busy, mem_req_valid}, 0);

        // shutdown in WAIT drains the late response
        start_miss(64'h4020_3ABC, 12'h005, 64'h1000);
        handshake();
        shutdown = 1'b1; tick(); shutdown = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_no_req", mem_req_valid, 0);
        tick();
        chk("drain_busy2", busy, 1);
        respond(64'h2001);
        chk("drain_done", {busy, insert, fault, mem_req_valid}, 0);
        run_vec(0);

        // second miss during the walk is ignored
        start_miss(64'h4020_3ABC, 12'h005, 64'h1000);
        handshake();
        miss = 1'b1; va = 64'h9000; pcid = 12'h007; root_pa = 64'h5000;
        tick();
        miss = 1'b0; va = '0; pcid = '0; root_pa = '0;
        chk("miss2_still_wait", {mem_req_valid, busy}, 2'b01);
        respond(64'h2001);
        chk("miss2_addr1", mem_req_addr, 64'h2008);
        handshake(); respond(64'h3001);
        chk("miss2_addr2", mem_req_addr, 64'h3018);
        handshake(); respond(64'h8000_5003);
        chk("miss2_insert", insert, 1);
        chk("miss2_ins_va", ins_va, 64'h4020_3ABC);
        chk("miss2_ins_pa", ins_pa, 64'h8000_5ABC);
        chk("miss2_ins_pcid", ins_pcid, 12'h005);
        tick();

        // shutdown together with the response in WAIT
        start_miss(64'h4020_3ABC, 12'h005, 64'h1000);
        handshake();
        shutdown = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h2001;
        tick();
        shutdown = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        chk("shut_rsp_idle", {busy, mem_req_valid, fault, insert}, 0);
        tick();
        chk("shut_rsp_stay", {busy, mem_req_valid}, 0);

        // shutdown wins over miss in IDLE
        shutdown = 1'b1;
        start_miss(64'h4020_3ABC, 12'h005, 64'h1000);
        shutdown = 1'b0;
        chk("shut_prio", {busy, mem_req_valid}, 0);

        // shutdown during INSERT suppresses the insert
        start_miss(64'h4020_3ABC, 12'h005, 64'h1000);
        handshake(); respond(64'h2001);
        handshake(); respond(64'h3001);
        handshake(); respond(64'h8000_5003);
        shutdown = 1'b1;
        #1;
        chk("shut_ins_no_insert", insert, 0);
        tick();
        shutdown = 1'b0;
        chk("shut_ins_idle", {busy, insert}, 0);

        // reset in WAIT, then a late response
        start_miss(64'h4020_3ABC, 12'h005, 64'h1000);
        handshake();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_ctrl", {busy, mem_req_valid, insert, fault}, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_ins", ins_pa | ins_va | 64'(ins_pcid), 0);
        respond(64'h8000_5003);
        chk("rst_late_rsp", {busy, mem_req_valid, insert, fault}, 0);
        tick();
        chk("rst_late_rsp2", {busy, insert, fault}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/page_walker.md
PAGE_WALKER -- requirements
Module: page_walker

Interface
REQ-001 SHALL have parameter SADDR, 64, address/PTE width.
REQ-002 SHALL have parameter SPAGE, 12, page offset bits.
REQ-003 SHALL have parameter SPCID, 12, pcid width.
REQ-004 SHALL have parameter NLEVEL, 3, table levels; 9 VA index bits per level; 8-byte PTEs.
REQ-005 SHALL have one clock and a synchronous, active-high reset (clk, rst).
REQ-006 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port miss  in  1  TLB miss pulse; va/pcid valid with it.
REQ-009 SHALL have ports va  in  SADDR and pcid  in  SPCID, the missing translation.
REQ-010 SHALL have port root_pa  in  SADDR  root table base, 4 KiB aligned.
REQ-011 SHALL have port shutdown  in  1  abort walk (same meaning as TLB clear).
REQ-012 SHALL have ports mem_req_valid  out  1, mem_req_ready  in  1, mem_req_addr  out  SADDR.
REQ-013 SHALL have ports mem_rsp_valid  in  1 and mem_rsp_data  in  SADDR  PTE read data.
REQ-014 SHALL have ports insert  out  1, ins_pa  out  SADDR, ins_va  out  SADDR, ins_pcid  out  SPCID, to the TLB insert path.
REQ-015 SHALL have ports fault  out  1  translation-fault pulse and busy  out  1  walk in progress.

Function
REQ-016 SHALL implement states IDLE, REQ, WAIT, INSERT, FAULT, DRAIN.
REQ-017 IDLE: miss=1 SHALL capture va, pcid, root_pa; set level=0; go to REQ; busy=1 from the next cycle.
REQ-018 miss while not IDLE SHALL be ignored, with no state change.
REQ-019 PTE address SHALL be base + 8*idx, where idx = va[SPAGE+9*(NLEVEL-level)-1 -: 9] and base = root_pa at level 0, else the previous PTE with bits [SPAGE-1:0] zeroed.
REQ-020 REQ: mem_req_valid=1 with a stable addr until mem_req_ready=1; the handshake cycle SHALL move to WAIT.
REQ-021 Exactly one request SHALL be outstanding; WAIT SHALL hold until mem_rsp_valid=1.
REQ-022 PTE format: bit0 V, bit1 L (leaf), [SADDR-1:SPAGE] frame.
REQ-023 Response handling:
- V=0 -> FAULT.
- L=1 below the last level -> FAULT.
- L=0 at the last level -> FAULT.
- L=0 below the last level -> level+1, then REQ.
- L=1 at the last level -> INSERT.
REQ-024 INSERT SHALL assert insert=1 for exactly one cycle with ins_pa={frame, va[SPAGE-1:0]}, ins_va=captured va, ins_pcid=captured pcid, then go to IDLE.
REQ-025 FAULT SHALL assert fault=1 for exactly one cycle, then go to IDLE.
REQ-026 Latency SHALL be exactly one cycle from rsp to the next mem_req_valid, insert, or fault.
REQ-027 shutdown in REQ or INSERT SHALL go to IDLE the next cycle, with no insert issued.
REQ-028 shutdown in WAIT SHALL go to DRAIN; DRAIN SHALL discard the response and then go to IDLE; busy stays 1 in DRAIN.
REQ-029 shutdown together with mem_rsp_valid in WAIT SHALL discard that response and go to IDLE.
REQ-030 shutdown takes priority over miss in IDLE.
REQ-031 ins_* SHALL hold their values outside INSERT; only insert qualifies them.

Reset
REQ-032 rst SHALL force IDLE, level=0, and all outputs to 0 (busy, mem_req_valid, mem_req_addr, insert, ins_*, fault).
REQ-033 rst mid-walk SHALL abandon the walk; a response arriving after reset SHALL be ignored in IDLE.

Structure
REQ-034 State encodings, the PTE bit positions (V, L) and the 9-bit index width SHALL live in a shared package/include next to the TLB state definitions.
REQ-035 The per-level address computation SHALL be one sub-module, pte_addr_gen (combinational: va, level, base -> addr).

Verification
REQ-036 Scenario: SADDR=64, NLEVEL=3, root_pa=0x1000, va=0x4020_3ABC, pcid=0x5.
- Requests SHALL be 0x1008, 0x2008, 0x3018, answered with PTEs 0x2001, 0x3001, 0x8000_5003.
- insert=1 SHALL follow with ins_pa=0x8000_5ABC and ins_pcid=0x5.
REQ-037 Same walk with a level-1 PTE of 0x3000 (V=0) -> fault=1 for one cycle, no third request, no insert.
REQ-038 mem_req_ready held at 0 for 5 cycles -> mem_req_addr SHALL stay 0x1008 and mem_req_valid SHALL stay 1 throughout.
REQ-039 shutdown in WAIT, response 2 cycles later -> DRAIN consumes it, then IDLE, no insert; a new miss next cycle walks normally.
REQ-040 Second miss (va=0x9000) mid-walk -> ignored; only the first va is inserted.
REQ-041 rst asserted in WAIT -> all outputs 0 next cycle; a late mem_rsp_valid SHALL cause no insert or fault.
